v_regfile_ew: RTL and testbench

//  Parametrised vector register file for the vector unit, with per-element write enables.

---
 rtl/v_regfile_ew.sv | 133 +++++++++++++
 tb/tb_v_regfile_ew.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/v_regfile_ew.sv
// Vector register file with per-element write enables, a per-register pending
// scoreboard and a one-register-per-cycle clear engine. Optional write->read
// bypass is enabled by defining VRF_BYPASS_EN.

module v_regfile_ew_lane #(
  parameter int ELEN = 64
) (
  input  logic            we_i,
  input  logic [ELEN-1:0] new_i,
  input  logic [ELEN-1:0] old_i,
  output logic [ELEN-1:0] out_o
);
  assign out_o = we_i ? new_i : old_i;
endmodule

module v_regfile_ew #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int ELEN  = 64,
  parameter int VLMAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_ena_i,
  input  logic [AW-1:0]         w_addr_i,
  input  logic [VLMAX*ELEN-1:0] w_data_i,
  input  logic [VLMAX-1:0]      w_emask_i,
  input  logic                  r_ena1_i,
  input  logic [AW-1:0]         r_addr1_i,
  output logic [VLMAX*ELEN-1:0] r_data1_o,
  output logic                  r_busy1_o,
  input  logic                  r_ena2_i,
  input  logic [AW-1:0]         r_addr2_i,
  output logic [VLMAX*ELEN-1:0] r_data2_o,
  output logic                  r_busy2_o,
  input  logic                  sb_set_i,
  input  logic [AW-1:0]         sb_addr_i,
  input  logic                  clr_i,
  output logic                  clr_busy_o
);
  typedef enum logic {S_IDLE, S_CLEAR} state_e;
  typedef logic [VLMAX-1:0][ELEN-1:0] vreg_t;

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS-1);

  vreg_t            regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;

  logic  clearing, wr_acc, sb_acc, rd_ok1, rd_ok2;
  vreg_t w_vec, w_old, w_mrg;

  assign clearing   = (state_q == S_CLEAR);
  assign clr_busy_o = clearing;
  assign wr_acc     = !clearing && w_ena_i  && ({1'b0, w_addr_i}  < NREGS_W);
  assign sb_acc     = !clearing && sb_set_i && ({1'b0, sb_addr_i} < NREGS_W);
  assign rd_ok1     = !clearing && ({1'b0, r_addr1_i} < NREGS_W);
  assign rd_ok2     = !clearing && ({1'b0, r_addr2_i} < NREGS_W);

  assign w_vec = w_data_i;
  assign w_old = regs_q[w_addr_i];

  for (genvar k = 0; k < VLMAX; k++) begin : g_lane
    v_regfile_ew_lane #(.ELEN(ELEN)) u_lane (
      .we_i  (w_emask_i[k]),
      .new_i (w_vec[k]),
      .old_i (w_old[k]),
      .out_o (w_mrg[k])
    );
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    case (state_q)
      S_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        // set after clear so a new producer wins over a same-index writeback
        if (wr_acc) pend_d[w_addr_i]  = 1'b0;
        if (sb_acc) pend_d[sb_addr_i] = 1'b1;
        if (clr_i) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          pend_d  = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end

  // Array has no reset: the sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (clearing)    regs_q[ptr_q]    <= '0;
    else if (wr_acc) regs_q[w_addr_i] <= w_mrg;
  end

`ifdef VRF_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wr_acc && (r_addr1_i == w_addr_i);
  assign byp2 = wr_acc && (r_addr2_i == w_addr_i);
  assign r_data1_o = (!rd_ok1 || !r_ena1_i) ? '0 : byp1 ? w_mrg : regs_q[r_addr1_i];
  assign r_data2_o = (!rd_ok2 || !r_ena2_i) ? '0 : byp2 ? w_mrg : regs_q[r_addr2_i];
  assign r_busy1_o = !rd_ok1 ? 1'b0 : byp1 ? (sb_acc && (sb_addr_i == r_addr1_i)) : pend_q[r_addr1_i];
  assign r_busy2_o = !rd_ok2 ? 1'b0 : byp2 ? (sb_acc && (sb_addr_i == r_addr2_i)) : pend_q[r_addr2_i];
`else
  assign r_data1_o = (rd_ok1 && r_ena1_i) ? regs_q[r_addr1_i] : '0;
  assign r_data2_o = (rd_ok2 && r_ena2_i) ? regs_q[r_addr2_i] : '0;
  assign r_busy1_o = rd_ok1 ? pend_q[r_addr1_i] : 1'b0;
  assign r_busy2_o = rd_ok2 ? pend_q[r_addr2_i] : 1'b0;
`endif

endmodule

// File: tb/tb_v_regfile_ew.sv
// Directed self-checking bench for v_regfile_ew (default NREGS=32, VLMAX=4, ELEN=64).

module tb_v_regfile_ew;
  logic         clk = 1'b0;
  logic         rst;
  logic         w_ena, r_ena1, r_ena2, sb_set, clr;
  logic [4:0]   w_addr, r_addr1, r_addr2, sb_addr;
  logic [255:0] w_data, r_data1, r_data2;
  logic [3:0]   w_emask;
  logic         r_busy1, r_busy2, clr_busy;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [255:0] A5 = {4{64'hA5A5_A5A5_A5A5_A5A5}};
  localparam logic [255:0] ON = {4{64'h1111_1111_1111_1111}};
  localparam logic [255:0] V0 = {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                                 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001};
  localparam logic [255:0] OLD = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [255:0] NEW = {4{64'hDEAD_BEEF_CAFE_F00D}};

  always #5 clk = ~clk;

  v_regfile_ew dut (
    .clk(clk), .rst(rst),
    .w_ena_i(w_ena), .w_addr_i(w_addr), .w_data_i(w_data), .w_emask_i(w_emask),
    .r_ena1_i(r_ena1), .r_addr1_i(r_addr1), .r_data1_o(r_data1), .r_busy1_o(r_busy1),
    .r_ena2_i(r_ena2), .r_addr2_i(r_addr2), .r_data2_o(r_data2), .r_busy2_o(r_busy2),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .clr_i(clr), .clr_busy_o(clr_busy)
  );

  // single-cycle write, starting and ending on a falling edge
  task automatic wr(input logic [4:0] a, input logic [255:0] d, input logic [3:0] m);
    w_ena = 1'b1; w_addr = a; w_data = d; w_emask = m;
    @(negedge clk);
    w_ena = 1'b0; w_emask = '0;
  endtask

  task automatic test_reset;
    int cnt;
    rst = 1'b1; r_ena1 = 1'b1; r_addr1 = 5'd3;
    #3;
    n_chk++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b exp 1", clr_busy); end
    n_chk++; if (r_data1 !== '0 || r_busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_read got %h/%b exp 0/0", r_data1, r_busy1); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 100) begin @(negedge clk); cnt++; end
    n_chk++; if (cnt !== 32) begin n_fail++; $display("FAIL reset_sweep_len got %0d exp 32", cnt); end
    r_ena2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r_addr1 = 5'(i); r_addr2 = 5'(31 - i); #1;
      n_chk++;
      if (r_data1 !== '0 || r_data2 !== '0 || r_busy1 !== 1'b0 || r_busy2 !== 1'b0) begin
        n_fail++; $display("FAIL reset_zero v%0d got %h/%b exp 0/0", i, r_data1, r_busy1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_mask;
    wr(5'd3, A5, 4'b0101);
    r_ena2 = 1'b1; r_addr2 = 5'd3; #1;
    n_chk++; if (r_data2 !== {64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5}) begin
      n_fail++; $display("FAIL mask_0101 got %h", r_data2); end
    wr(5'd3, ON, 4'b1010); #1;
    n_chk++; if (r_data2 !== {64'h1111_1111_1111_1111, 64'hA5A5_A5A5_A5A5_A5A5, 64'h1111_1111_1111_1111, 64'hA5A5_A5A5_A5A5_A5A5}) begin
      n_fail++; $display("FAIL mask_1010 got %h", r_data2); end
    wr(5'd3, '1, 4'b0000); #1;
    n_chk++; if (r_data2 !== {64'h1111_1111_1111_1111, 64'hA5A5_A5A5_A5A5_A5A5, 64'h1111_1111_1111_1111, 64'hA5A5_A5A5_A5A5_A5A5}) begin
      n_fail++; $display("FAIL mask_none got %h", r_data2); end
    wr(5'd0, V0, 4'b1111);
    r_ena1 = 1'b1; r_addr1 = 5'd0; #1;
    n_chk++; if (r_data1 !== V0) begin n_fail++; $display("FAIL v0_roundtrip got %h exp %h", r_data1, V0); end
    r_ena1 = 1'b0; #1;
    n_chk++; if (r_data1 !== '0) begin n_fail++; $display("FAIL read_disabled got %h exp 0", r_data1); end
    @(negedge clk);
  endtask

  task automatic test_scoreboard;
    sb_set = 1'b1; sb_addr = 5'd7;
    @(negedge clk);
    sb_set = 1'b0; r_ena1 = 1'b0; r_addr1 = 5'd7; r_addr2 = 5'd8; #1;
    n_chk++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_set got %b exp 1", r_busy1); end
    n_chk++; if (r_busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_other got %b exp 0", r_busy2); end
    w_ena = 1'b1; w_addr = 5'd7; w_data = '0; w_emask = 4'b0000; #1;
`ifdef VRF_BYPASS_EN
    n_chk++; if (r_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_wb_same_cycle got %b exp 0", r_busy1); end
`else
    n_chk++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_wb_same_cycle got %b exp 1", r_busy1); end
`endif
    @(negedge clk);
    w_ena = 1'b0; #1;
    n_chk++; if (r_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_wb_clear got %b exp 0", r_busy1); end
    sb_set = 1'b1; sb_addr = 5'd7; w_ena = 1'b1; w_addr = 5'd7;
    @(negedge clk);
    sb_set = 1'b0; w_ena = 1'b0; #1;
    n_chk++; if (r_busy1 !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b exp 1", r_busy1); end
    @(negedge clk);
    wr(5'd7, '0, 4'b0000); #1;
    n_chk++; if (r_busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_wb_after got %b exp 0", r_busy1); end
    @(negedge clk);
  endtask

  task automatic test_bypass;
    logic [255:0] mrg;
    mrg = {OLD[255:128], NEW[127:0]};
    wr(5'd5, OLD, 4'b1111);
    r_ena1 = 1'b1; r_addr1 = 5'd5; r_ena2 = 1'b1; r_addr2 = 5'd5;
    w_ena = 1'b1; w_addr = 5'd5; w_data = NEW; w_emask = 4'b0011; #1;
`ifdef VRF_BYPASS_EN
    n_chk++; if (r_data1 !== mrg) begin n_fail++; $display("FAIL bypass_same_cycle got %h exp %h", r_data1, mrg); end
`else
    n_chk++; if (r_data1 !== OLD) begin n_fail++; $display("FAIL nobypass_old got %h exp %h", r_data1, OLD); end
`endif
    @(negedge clk);
    w_ena = 1'b0; w_emask = '0; #1;
    n_chk++; if (r_data1 !== mrg || r_data2 !== mrg) begin n_fail++; $display("FAIL write_new got %h exp %h", r_data1, mrg); end
    @(negedge clk);
  endtask

  task automatic test_clear;
    int cnt;
    wr(5'd1, ON, 4'b1111);
    wr(5'd2, A5, 4'b1111);
    sb_set = 1'b1; sb_addr = 5'd9;
    @(negedge clk);
    sb_set = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    r_ena1 = 1'b1; r_addr1 = 5'd2; r_ena2 = 1'b1; r_addr2 = 5'd9; #1;
    n_chk++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clr_start got %b exp 1", clr_busy); end
    n_chk++; if (r_data1 !== '0 || r_busy2 !== 1'b0) begin n_fail++; $display("FAIL clr_reads got %h/%b exp 0/0", r_data1, r_busy2); end
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      w_ena = (cnt == 5); w_addr = 5'd1; w_data = '1; w_emask = 4'hF;
      sb_set = (cnt == 5); sb_addr = 5'd4;
      clr = (cnt == 20);
      @(negedge clk);
      cnt++;
    end
    w_ena = 1'b0; sb_set = 1'b0; clr = 1'b0; w_emask = '0;
    n_chk++; if (cnt !== 32) begin n_fail++; $display("FAIL clr_sweep_len got %0d exp 32", cnt); end
    for (int i = 0; i < 32; i++) begin
      r_addr1 = 5'(i); r_addr2 = 5'(i); #1;
      n_chk++;
      if (r_data1 !== '0 || r_busy1 !== 1'b0 || r_busy2 !== 1'b0) begin
        n_fail++; $display("FAIL clr_zero v%0d got %h/%b exp 0/0", i, r_data1, r_busy1);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midsweep;
    int cnt;
    wr(5'd20, NEW, 4'b1111);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; r_ena1 = 1'b1; r_addr1 = 5'd20; #1;
    n_chk++; if (clr_busy !== 1'b1 || r_data1 !== '0) begin n_fail++; $display("FAIL mid_rst got %b/%h exp 1/0", clr_busy, r_data1); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (clr_busy && cnt < 100) begin @(negedge clk); cnt++; end
    n_chk++; if (cnt !== 32) begin n_fail++; $display("FAIL mid_rst_sweep_len got %0d exp 32", cnt); end
    #1;
    n_chk++; if (r_data1 !== '0 || r_busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_zero got %h/%b exp 0/0", r_data1, r_busy1); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; w_ena = 1'b0; w_addr = '0; w_data = '0; w_emask = '0;
    r_ena1 = 1'b0; r_addr1 = '0; r_ena2 = 1'b0; r_addr2 = '0;
    sb_set = 1'b0; sb_addr = '0; clr = 1'b0;
    test_reset;
    test_write_mask;
    test_scoreboard;
    test_bypass;
    test_clear;
    test_reset_midsweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
